// File: rtl/snake_state_reader.sv
// snake_state_reader: indexed 32-bit reader of the snake game-state bus for the renderer.
// Define SNAKE_READER_SNAPSHOT_EN for a vsync-coherent shadow copy; otherwise reads sample live state.
module snake_state_reader #(
  parameter int unsigned STATE_W = 996,
  parameter int unsigned FIRST_IDX = 100,
  parameter int unsigned LAST_IDX = 137
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] state_in,
  input  logic               vsync_start,
  input  logic               rd_req,
  input  logic [31:0]        rd_index,
  input  logic               rd_ack,
  output logic               rd_valid,
  output logic [31:0]        rd_data,
  output logic               rd_error,
  output logic               snap_pending,
  output logic [15:0]        frame_count
);
  typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;
  state_t state, next;
  logic capture, accept, in_map, narrow;
  logic [31:0] k, off, word;
  logic [STATE_W-1:0] src;
`ifdef SNAKE_READER_SNAPSHOT_EN
  logic [STATE_W-1:0] shadow;
  assign src = shadow;
  assign capture = state == IDLE && (vsync_start || snap_pending);
`else
  assign src = state_in;
  assign capture = 1'b0;
  assign snap_pending = 1'b0;
`endif
  // Data is resolved at acceptance; the source cannot change while a read is outstanding.
  always_comb begin
    k = rd_index - FIRST_IDX;
    in_map = rd_index >= FIRST_IDX && rd_index <= LAST_IDX;
    narrow = k >= 32'd10 && k < 32'd30;
    off = k < 32'd10 ? 32'd200 + (k << 5) : narrow ? 32'd520 + (k - 32'd10) * 32'd11 : 32'd740 + ((k - 32'd30) << 5);
    word = 32'(src >> off) & (narrow ? 32'h0000_07FF : 32'hFFFF_FFFF);
    accept = state == IDLE && !capture && rd_req;
    next = capture ? CAPTURE : accept ? RESP : (state == CAPTURE || (state == RESP && rd_ack)) ? IDLE : state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_error <= 1'b0;
      frame_count <= '0;
`ifdef SNAKE_READER_SNAPSHOT_EN
      shadow <= '0;
      snap_pending <= 1'b0;
`endif
    end else begin
      state <= next;
      if (accept) begin
        rd_valid <= 1'b1;
        rd_data <= in_map ? word : 32'd0;
        rd_error <= !in_map;
      end else if (state == RESP && rd_ack) rd_valid <= 1'b0;
`ifdef SNAKE_READER_SNAPSHOT_EN
      if (state == CAPTURE) begin
        shadow <= state_in;
        frame_count <= frame_count + 16'd1;
        snap_pending <= 1'b0;
      end else if (state == RESP && vsync_start) snap_pending <= 1'b1;
`else
      if (vsync_start) frame_count <= frame_count + 16'd1;
`endif
    end
endmodule

// File: tb/tb_snake_state_reader.sv
// tb_snake_state_reader: directed bench for snake_state_reader; expectations follow SNAKE_READER_SNAPSHOT_EN.
module tb_snake_state_reader;
`ifdef SNAKE_READER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, vsync_start = 1'b0, rd_req = 1'b0, rd_ack = 1'b0;
  logic [995:0] st = '0;
  logic [31:0] rd_index = '0, rd_data;
  logic rd_valid, rd_error, snap_pending;
  logic [15:0] frame_count;
  int errors = 0, checks = 0;

  snake_state_reader dut (
    .clock(clock), .reset(reset), .state_in(st), .vsync_start(vsync_start),
    .rd_req(rd_req), .rd_index(rd_index), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_error(rd_error), .snap_pending(snap_pending), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic vsync();
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [31:0] idx, input int hold, output logic [31:0] d, output logic e, output int lat);
    rd_index = idx;
    rd_req = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!rd_valid && lat < 8);
    rd_req = 1'b0;
    d = rd_data;
    e = rd_error;
    repeat (hold) tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", rd_data); end
    checks++; if (rd_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", rd_error); end
    checks++; if (snap_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", snap_pending); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d expected 0", frame_count); end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] d; logic e; int lat;
    st[231:200] = 32'h0000_1234;
    vsync();
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frames: got %0d expected 1", frame_count); end
    do_read(32'd100, 0, d, e, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_latency: got %0d expected 1", lat); end
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL basic_data: got %h expected 00001234", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_error: got %b expected 0", e); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", rd_valid); end
  endtask

  task automatic test_map();
    logic [31:0] d; logic e; int lat;
    logic [31:0] idx [7] = '{32'd109, 32'd115, 32'd129, 32'd137, 32'd99, 32'd138, 32'h8000_0064};
    logic [31:0] exp_d [7] = '{32'hCAFE_F00D, 32'h0000_05A3, 32'h0000_07FF, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0};
    logic exp_e [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    st[519:488] = 32'hCAFE_F00D;
    st[585:575] = 11'h5A3;
    st[574] = 1'b1;
    st[586] = 1'b1;
    st[739:729] = 11'h7FF;
    st[995:964] = 32'hDEAD_BEEF;
    vsync();
    for (int i = 0; i < 7; i++) begin
      do_read(idx[i], 0, d, e, lat);
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL map_data idx %0d: got %h expected %h", idx[i], d, exp_d[i]); end
      checks++; if (e !== exp_e[i]) begin errors++; $display("FAIL map_error idx %0d: got %b expected %b", idx[i], e, exp_e[i]); end
    end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL map_frames: got %0d expected 2", frame_count); end
  endtask

  task automatic test_coherence();
    logic [31:0] d; logic e; int lat;
    st[867:836] = 32'd7;
    vsync();
    st[867:836] = 32'd9;
    do_read(32'd133, 0, d, e, lat);
    checks++; if (d !== (SNAP ? 32'd7 : 32'd9)) begin errors++; $display("FAIL coherent_old: got %h expected %h", d, SNAP ? 32'd7 : 32'd9); end
    vsync();
    do_read(32'd133, 0, d, e, lat);
    checks++; if (d !== 32'd9) begin errors++; $display("FAIL coherent_new: got %h expected 9", d); end
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL coherent_frames: got %0d expected 4", frame_count); end
  endtask

  task automatic test_pending();
    logic [31:0] d; logic e; int lat;
    logic [31:0] held;
    held = SNAP ? 32'd9 : 32'd11;
    st[867:836] = 32'd11;
    rd_index = 32'd133;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL pend_valid: got %b expected 1", rd_valid); end
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    st[867:836] = 32'd13;
    checks++; if (snap_pending !== SNAP) begin errors++; $display("FAIL pend_flag: got %b expected %b", snap_pending, SNAP); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== held || rd_valid !== 1'b1) begin errors++; $display("FAIL pend_hold %0d: got %h/%b expected %h/1", i, rd_data, rd_valid, held); end
      tick();
    end
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    checks++; if (rd_data !== held) begin errors++; $display("FAIL pend_hold_last: got %h expected %h", rd_data, held); end
    checks++; if (frame_count !== (SNAP ? 16'd4 : 16'd6)) begin errors++; $display("FAIL pend_frames_hold: got %0d expected %0d", frame_count, SNAP ? 4 : 6); end
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL pend_ack: got %b expected 0", rd_valid); end
    checks++; if (snap_pending !== SNAP) begin errors++; $display("FAIL pend_flag_after_ack: got %b expected %b", snap_pending, SNAP); end
    tick();
    checks++; if (frame_count !== (SNAP ? 16'd4 : 16'd6)) begin errors++; $display("FAIL pend_frames_capture: got %0d expected %0d", frame_count, SNAP ? 4 : 6); end
    tick();
    checks++; if (frame_count !== (SNAP ? 16'd5 : 16'd6)) begin errors++; $display("FAIL pend_frames_done: got %0d expected %0d", frame_count, SNAP ? 5 : 6); end
    checks++; if (snap_pending !== 1'b0) begin errors++; $display("FAIL pend_flag_clear: got %b expected 0", snap_pending); end
    do_read(32'd133, 0, d, e, lat);
    checks++; if (d !== 32'd13) begin errors++; $display("FAIL pend_new_data: got %h expected 0000000d", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL pend_new_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_collision();
    int lat;
    st[231:200] = 32'h5555_AAAA;
    rd_index = 32'd100;
    rd_req = 1'b1;
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    checks++; if (rd_valid !== !SNAP) begin errors++; $display("FAIL coll_first: got %b expected %b", rd_valid, !SNAP); end
    lat = 1;
    while (!rd_valid && lat < 8) begin tick(); lat++; end
    rd_req = 1'b0;
    checks++; if (lat !== (SNAP ? 3 : 1)) begin errors++; $display("FAIL coll_latency: got %0d expected %0d", lat, SNAP ? 3 : 1); end
    checks++; if (rd_data !== 32'h5555_AAAA) begin errors++; $display("FAIL coll_data: got %h expected 5555aaaa", rd_data); end
    checks++; if (frame_count !== (SNAP ? 16'd6 : 16'd7)) begin errors++; $display("FAIL coll_frames: got %0d expected %0d", frame_count, SNAP ? 6 : 7); end
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat;
    rd_index = 32'd100;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b expected 1", rd_valid); end
    checks++; if (snap_pending !== SNAP) begin errors++; $display("FAIL mid_pending: got %b expected %b", snap_pending, SNAP); end
    #2 reset = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_drop: got %b expected 0", rd_valid); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL mid_frames: got %0d expected 0", frame_count); end
    checks++; if (snap_pending !== 1'b0) begin errors++; $display("FAIL mid_pending_drop: got %b expected 0", snap_pending); end
    #2 reset = 1'b1;
    tick();
    do_read(32'd100, 0, d, e, lat);
    checks++; if (d !== (SNAP ? 32'd0 : 32'h5555_AAAA)) begin errors++; $display("FAIL mid_read: got %h expected %h", d, SNAP ? 32'd0 : 32'h5555_AAAA); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL mid_latency: got %0d expected 1", lat); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL mid_frames_after: got %0d expected 0", frame_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_map();
    test_coherence();
    test_pending();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/snake_state_reader.md
Name: snake_state_reader

Overview:
- Read-side counterpart of the snake game-state register file.
- The register file is written by the processor by index and exposes one flat 996-bit state bus. This block takes a frame-coherent snapshot of that bus at each vertical-sync start.
- It then serves indexed 32-bit reads to the VGA renderer over a req/valid/ack handshake, using the same index map the processor uses to write.

Parameters:
- STATE_W, 996, width of the flat state bus
- FIRST_IDX, 100, lowest readable index
- LAST_IDX, 137, highest readable index

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- state_in  in  996  flat game-state bus from the register file
- vsync_start  in  1  one-cycle pulse at start of vertical blank
- rd_req  in  1  read request from renderer
- rd_index  in  32  field index for the read
- rd_ack  in  1  renderer has consumed rd_data
- rd_valid  out  1  rd_data/rd_error are valid
- rd_data  out  32  field value, zero-extended
- rd_error  out  1  index outside the map
- snap_pending  out  1  capture deferred behind an in-flight read
- frame_count  out  16  number of completed snapshots

Behaviour:
- Reset (reset=0, async): state IDLE; rd_valid=0, rd_data=0, rd_error=0, snap_pending=0, frame_count=0, shadow=0.
- Index map (bit offsets into the shadow copy):
  - 100..109: 32-bit field at 200+32*(i-100).
  - 110..129: 11-bit field at 520+11*(i-110), zero-extended to 32 bits.
  - 130..137: 32-bit field at 740+32*(i-130).
  - Any other index (including 0..99): rd_data=0, rd_error=1.
- FSM states: IDLE, CAPTURE, RESP.
- IDLE:
  - vsync_start=1 or snap_pending=1 -> CAPTURE. Capture has priority over rd_req in the same cycle; the request is not accepted and the renderer keeps rd_req high.
  - Otherwise rd_req=1 -> latch rd_index, go to RESP.
- CAPTURE (1 cycle):
  - shadow <= state_in; frame_count += 1, wrapping 0xFFFF -> 0; snap_pending <= 0.
  - Then -> IDLE.
- RESP:
  - rd_valid=1 exactly one cycle after acceptance.
  - rd_data and rd_error are taken from the shadow at the latched index and held stable while rd_valid=1.
  - rd_ack=1 -> rd_valid=0 next cycle, -> IDLE.
  - rd_ack asserted together with rd_valid's first cycle is legal, giving a 2-cycle transaction.
- vsync_start during RESP: snap_pending <= 1. The capture runs in the first IDLE cycle after the ack, so no read ever mixes two frames.
- A second vsync_start while snap_pending=1 is absorbed: one capture, frame_count +1 only.
- rd_req in RESP is ignored. rd_index changes after acceptance have no effect.
- rd_ack outside RESP is ignored.
- Reset mid-transaction: rd_valid drops immediately (async); the pending capture is discarded.
- Throughput: at most one read per 2 cycles; capture latency is at most 1 cycle plus the outstanding read.

Optional Feature:
- Macro: SNAKE_READER_SNAPSHOT_EN.
- Defined: shadow register and CAPTURE state present, behaving exactly as above.
- Undefined:
  - No shadow; rd_data is sampled from live state_in at acceptance.
  - vsync_start only increments frame_count, in 1 cycle with no FSM visit.
  - snap_pending is tied to 0.

Test Plan:
1. Reset release; vsync_start; state_in bits[231:200]=0x0000_1234; read idx 100 -> rd_valid one cycle after accept, rd_data=0x0000_1234, rd_error=0, frame_count=1.
2. Field idx 115 = 11'h5A3 at bits[585:575]; read idx 115 -> rd_data=0x0000_05A3. Read idx 137 -> bits[995:964]. Read idx 99 and idx 138 -> rd_data=0, rd_error=1.
3. Snapshot coherence: capture with idx 133 = 7, change state_in to 9 without a vsync, read 133 -> 7. Then vsync, read 133 -> 9.
4. vsync_start during RESP with rd_ack held off 5 cycles -> snap_pending=1; rd_data unchanged until ack; capture in the cycle after IDLE is re-entered; frame_count +1.
5. rd_req and vsync_start in the same IDLE cycle -> capture first; request accepted the next cycle and returns new-frame data.
6. Assert reset while rd_valid=1 with a pending snap -> rd_valid=0 and frame_count=0 immediately; after release, the first read returns 0 (empty shadow).
